// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch unit's bus signals: the instruction-memory request /
//   response port, the decoded-instruction hand-off to the control decoder,
//   and the branch redirect strobe from execute.
//
//   Modports
//     master : the fetch unit (drives imem_req/imem_addr and the instr head)
//     slave  : the environment (memory, decoder, execute)
//
//   Signals
//     imem_req      fetch request valid
//     imem_addr     fetch address, word aligned
//     imem_ready    memory accepts request (handshake = req & ready)
//     imem_rvalid   read data valid, in order, one per accepted request
//     imem_rdata    returned instruction word
//     instr_valid   buffer head valid
//     instr         buffer head instruction
//     instr_pc      PC of the buffer head
//     op_code       instr[6:0], feeds the control decoder
//     instr_ready   consumer pops the head (pop = valid & ready)
//     branch_taken  one-cycle redirect strobe
//     branch_target redirect address
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [6:0]        op_code;
  logic              instr_ready;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, op_code,
    input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
           branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, op_code,
    output imem_ready, imem_rvalid, imem_rdata, instr_ready,
           branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Instruction fetch front end. Issues at most one instruction-memory request
//   at a time, buffers returned words together with their PC in a small
//   circular FIFO, and presents the head entry (instr / instr_pc / op_code) to
//   the control decoder. A taken branch flushes the buffer, redirects the
//   fetch PC and discards the one response that may still be in flight.
//
//   Ports
//     clk   single clock, all state updates on posedge
//     rst   asynchronous reset, active-high
//     bus   instr_fetch_unit_if.master (memory port, instr head, redirect)
//
//   Optional build macro FETCH_PERF_EN adds:
//     perf_fetched[31:0]  number of words pushed into the buffer (wraps)
//     perf_flushes[31:0]  number of redirect cycles (wraps)
//
//   FSM
//     state    | meaning
//     ST_RUN   | normal operation, responses are pushed into the buffer
//     ST_DRAIN | redirect hit an in-flight request; next rvalid is discarded
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_flushes
`endif
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t             state;
  logic               started;
  logic               outstanding;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [ADDR_W-1:0]  req_pc;
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               head_valid;
  logic [31:0]        head_instr;
  logic [ADDR_W-1:0]  head_pc;

  logic [31:0]        mem_instr [BUF_DEPTH];
  logic [ADDR_W-1:0]  mem_pc    [BUF_DEPTH];

  logic               req;
  logic               hs;
  logic               resp;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   cnt_after_pop;
  logic [CNT_W-1:0]   count_next;
  logic [PTR_W-1:0]   rd_ptr_next;

  // The buffer slot is reserved when the request is issued; with a single
  // outstanding request that reduces to count < BUF_DEPTH. `started` keeps
  // the request low until the first clock edge after reset release.
  assign req  = started && !bus.branch_taken && !outstanding && (count < DEPTH_C);
  assign hs   = req && bus.imem_ready;
  // Only a response to an accepted request is meaningful.
  assign resp = bus.imem_rvalid && outstanding;
  assign push = resp && (state == ST_RUN) && !bus.branch_taken;
  assign pop  = head_valid && bus.instr_ready && !bus.branch_taken;

  assign cnt_after_pop = count - CNT_W'(pop);
  assign count_next    = cnt_after_pop + CNT_W'(push);
  assign rd_ptr_next   = rd_ptr + PTR_W'(pop);

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = head_valid;
  assign bus.instr       = head_instr;
  assign bus.instr_pc    = head_pc;
  assign bus.op_code     = head_instr[6:0];

  // Storage array carries no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.imem_rdata;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      started     <= 1'b0;
      outstanding <= 1'b0;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      head_valid  <= 1'b0;
      head_instr  <= '0;
      head_pc     <= '0;
    end else begin
      started <= 1'b1;

      if (hs) begin
        outstanding <= 1'b1;
        req_pc      <= fetch_pc;
      end else if (resp) begin
        outstanding <= 1'b0;
      end

      if (bus.branch_taken) begin
        fetch_pc <= bus.branch_target & ALIGN_MASK;
      end else if (hs) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
      end

      // A redirect that coincides with the response discards it directly,
      // so draining is only needed when the response is still to come.
      case (state)
        ST_RUN: begin
          if (bus.branch_taken && outstanding && !bus.imem_rvalid) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (resp) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase

      if (bus.branch_taken) begin
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        head_valid <= 1'b0;
      end else begin
        count      <= count_next;
        rd_ptr     <= rd_ptr_next;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        head_valid <= (count_next != '0);
        // Head registers mirror the FIFO entry at rd_ptr_next. The pushed
        // word becomes the head only if nothing else remains after the pop.
        if (push && (cnt_after_pop == '0)) begin
          head_instr <= bus.imem_rdata;
          head_pc    <= req_pc;
        end else if (pop && (cnt_after_pop != '0)) begin
          head_instr <= mem_instr[rd_ptr_next];
          head_pc    <= mem_pc[rd_ptr_next];
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (push) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (bus.branch_taken) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule
